// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared code-rate constants, slicer state type and beat-count helper
package codec_pkg;

  localparam logic [1:0] CODE_RATE_2 = 2'd2;
  localparam logic [1:0] CODE_RATE_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } slicer_state_t;

  // Number of rx beats needed to carry one decoder frame.
  function automatic int rx_beats(input int steps, input int groups);
    return steps / groups;
  endfunction

endpackage

// File: rtl/frame_slicer_piso_stream.sv
// rtl/frame_slicer_piso_stream.sv - parallel-in/serial-out frame streamer with valid/ready and last flag
module piso_stream #(
  parameter int FRAME_W = 192,
  parameter int GROUP_W = 1,
  parameter int GROUPS  = 1,
  parameter int BEATS   = 192,
  parameter int N_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [FRAME_W-1:0]        frame_i,
  input  logic [N_W-1:0]            n_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [GROUPS*GROUP_W-1:0] data_o,
  output logic                      last_o
);

  localparam int WIN_W = GROUPS * GROUP_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   win_sh;
  logic               xfer;

  // The frame is kept left-aligned, so the next symbols always sit at the top.
  assign win     = shift_q[FRAME_W-1 -: WIN_W];
  assign valid_o = (cnt_q != '0);
  assign last_o  = (cnt_q == CNT_W'(1));
  assign xfer    = valid_o && ready_i;

  // Load a fresh frame, or advance by one beat worth of symbols on a transfer.
  always_comb begin
    shift_d = shift_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = frame_i;
      n_d     = n_i;
      cnt_d   = CNT_W'(BEATS);
    end else if (xfer) begin
      shift_d = shift_q << (GROUPS * int'(n_q));
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Spread the top GROUPS*n bits into groups; earliest symbol lands in bit 0 of group 0.
  always_comb begin
    data_o = '0;
    win_sh = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int k = 0; k < GROUP_W; k++) begin
        if (k < int'(n_q)) begin
          win_sh = win << (g * int'(n_q) + k);
          data_o[g*GROUP_W + k] = win_sh[WIN_W-1];
        end
      end
    end
  end

  // Shift register, rate and beat counter; a reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_slicer.sv
// rtl/frame_slicer.sv - latches encoder/decoder frames and streams them to encoder and Viterbi BMU
module frame_slicer #(
  parameter int TX_FRAME_W = 192,
  parameter int RX_STEPS   = 128,
  parameter int MAX_N      = 3,
  parameter int RX_GROUPS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [1:0]                    i_code_n,
  input  logic [TX_FRAME_W-1:0]         i_enc_frame,
  input  logic [MAX_N*RX_STEPS-1:0]     i_dec_frame,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_tx_data,
  output logic                          o_tx_last,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [RX_GROUPS*MAX_N-1:0]    o_rx_data,
  output logic                          o_rx_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  import codec_pkg::*;

  localparam int RX_FRAME_W = MAX_N * RX_STEPS;
  localparam int RX_BEATS   = rx_beats(RX_STEPS, RX_GROUPS);

  if ((RX_STEPS % RX_GROUPS) != 0) begin : g_bad_groups
    $error("RX_STEPS must be a multiple of RX_GROUPS");
  end

  slicer_state_t         state_q, state_d;
  logic                  code_ok;
  logic                  load;
  logic                  err_q, err_d;
  logic [RX_FRAME_W-1:0] dec_aligned;

  // Only rates 2..MAX_N are supported by the branch-metric unit.
  assign code_ok = (i_code_n == CODE_RATE_2) ||
                   ((i_code_n == CODE_RATE_3) && (MAX_N >= 3));

  // Symbols sit in the low N*RX_STEPS bits; move them to the top so the streamer starts there.
  always_comb begin
    dec_aligned = i_dec_frame;
    if (code_ok) begin
      dec_aligned = i_dec_frame << ((MAX_N - int'(i_code_n)) * RX_STEPS);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: run until both streams have drained, then one FINISH cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_start && code_ok) state_d = ST_RUN;
      ST_RUN:    if (!o_tx_valid && !o_rx_valid) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: start acceptance, error request, busy and done.
  always_comb begin
    load   = (state_q == ST_IDLE) && i_start && code_ok;
    err_d  = (state_q == ST_IDLE) && i_start && !code_ok;
    o_busy = (state_q == ST_RUN);
    o_done = (state_q == ST_FINISH);
  end

  // Error pulse appears the cycle after the rejected start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;

  piso_stream #(
    .FRAME_W (TX_FRAME_W),
    .GROUP_W (1),
    .GROUPS  (1),
    .BEATS   (TX_FRAME_W),
    .N_W     (2)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .frame_i (i_enc_frame),
    .n_i     (2'd1),
    .valid_o (o_tx_valid),
    .ready_i (i_tx_ready),
    .data_o  (o_tx_data),
    .last_o  (o_tx_last)
  );

  piso_stream #(
    .FRAME_W (RX_FRAME_W),
    .GROUP_W (MAX_N),
    .GROUPS  (RX_GROUPS),
    .BEATS   (RX_BEATS),
    .N_W     (2)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .frame_i (dec_aligned),
    .n_i     (i_code_n),
    .valid_o (o_rx_valid),
    .ready_i (i_rx_ready),
    .data_o  (o_rx_data),
    .last_o  (o_rx_last)
  );

endmodule

// File: tb/tb_frame_slicer.sv
// tb/tb_frame_slicer.sv - self-checking bench for frame_slicer
module tb_frame_slicer;

  localparam int TXW   = 192;
  localparam int STEPS = 128;
  localparam int MAXN  = 3;
  localparam int GR    = 2;
  localparam int RXW   = MAXN * STEPS;
  localparam int DW    = GR * MAXN;
  localparam int BEATS = STEPS / GR;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_start = 1'b0;
  logic [1:0]     i_code_n = 2'd0;
  logic [TXW-1:0] i_enc_frame = '0;
  logic [RXW-1:0] i_dec_frame = '0;
  logic           i_tx_ready = 1'b0;
  logic           i_rx_ready = 1'b0;
  logic           o_tx_valid, o_tx_data, o_tx_last;
  logic           o_rx_valid, o_rx_last;
  logic [DW-1:0]  o_rx_data;
  logic           o_busy, o_done, o_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_slicer #(
    .TX_FRAME_W (TXW),
    .RX_STEPS   (STEPS),
    .MAX_N      (MAXN),
    .RX_GROUPS  (GR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_code_n    (i_code_n),
    .i_enc_frame (i_enc_frame),
    .i_dec_frame (i_dec_frame),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_last   (o_tx_last),
    .o_rx_valid  (o_rx_valid),
    .i_rx_ready  (i_rx_ready),
    .o_rx_data   (o_rx_data),
    .o_rx_last   (o_rx_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  typedef struct {
    logic [1:0]     n;
    logic [TXW-1:0] enc;
    logic [RXW-1:0] dec;
    bit             rnd;
    bit             poke;
    logic [DW-1:0]  first_rx;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] all_outs();
    return {o_tx_valid, o_tx_data, o_tx_last, o_rx_valid, o_rx_data, o_rx_last, o_busy, o_done, o_err};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [TXW-1:0] enc_sh;
    logic [RXW-1:0] dec_sh;
    logic [DW-1:0]  exp_beat, p_rxd;
    logic           p_txd, p_txl, p_rxl, pv_tx, pv_rx;
    int tx_n, rx_n, done_n, cyc, stall_err, tx_bad, rx_bad, txl_bad, rxl_bad, err_seen;
    bit done_seen;
    enc_sh = v.enc;
    dec_sh = v.dec << ((MAXN - int'(v.n)) * STEPS);
    tx_n = 0; rx_n = 0; done_n = 0; cyc = 0; stall_err = 0;
    tx_bad = 0; rx_bad = 0; txl_bad = 0; rxl_bad = 0; err_seen = 0;
    pv_tx = 1'b0; pv_rx = 1'b0; p_txd = 1'b0; p_txl = 1'b0; p_rxl = 1'b0; p_rxd = '0;
    done_seen = 1'b0;

    @(negedge clk);
    i_code_n = v.n; i_enc_frame = v.enc; i_dec_frame = v.dec; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, " busy_after_start"}, o_busy, 1'b1);
    check({tag, " valids_after_start"}, {o_tx_valid, o_rx_valid}, 2'b11);
    check({tag, " first_tx_bit"}, o_tx_data, v.enc[TXW-1]);
    check({tag, " first_rx_beat"}, o_rx_data, v.first_rx);

    while (!done_seen && cyc < 5000) begin
      if (pv_tx && (!o_tx_valid || o_tx_data !== p_txd || o_tx_last !== p_txl)) stall_err++;
      if (pv_rx && (!o_rx_valid || o_rx_data !== p_rxd || o_rx_last !== p_rxl)) stall_err++;
      if (o_err) err_seen++;
      if (o_done) begin
        done_n++;
        done_seen = 1'b1;
      end else begin
        if (v.poke && cyc == 10) begin
          i_start = 1'b1; i_code_n = 2'd1; i_enc_frame = ~v.enc; i_dec_frame = ~v.dec;
        end else begin
          i_start = 1'b0;
        end
        i_tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        i_rx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (o_tx_valid && i_tx_ready) begin
          if (o_tx_data !== enc_sh[TXW-1]) tx_bad++;
          if (o_tx_last !== (tx_n == TXW - 1)) txl_bad++;
          enc_sh = enc_sh << 1;
          tx_n++;
        end
        if (o_rx_valid && i_rx_ready) begin
          exp_beat = '0;
          for (int g = 0; g < GR; g++) begin
            for (int k = 0; k < int'(v.n); k++) begin
              if (dec_sh[RXW-1]) exp_beat = exp_beat | (DW'(1) << (g * MAXN + k));
              dec_sh = dec_sh << 1;
            end
          end
          if (o_rx_data !== exp_beat) rx_bad++;
          if (o_rx_last !== (rx_n == BEATS - 1)) rxl_bad++;
          rx_n++;
        end
        pv_tx = o_tx_valid && !i_tx_ready; p_txd = o_tx_data; p_txl = o_tx_last;
        pv_rx = o_rx_valid && !i_rx_ready; p_rxd = o_rx_data; p_rxl = o_rx_last;
        @(negedge clk);
        cyc++;
      end
    end

    check({tag, " busy_low_at_done"}, o_busy, 1'b0);
    if (v.poke) begin
      i_code_n = v.n; i_enc_frame = v.enc; i_dec_frame = v.dec; i_start = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) done_n++;
      if (o_err) err_seen++;
    end
    check({tag, " done_pulses"}, done_n, 1);
    check({tag, " idle_after_done"}, {o_busy, o_tx_valid, o_rx_valid}, 3'b000);
    check({tag, " tx_count"}, tx_n, TXW);
    check({tag, " rx_count"}, rx_n, BEATS);
    check({tag, " tx_data_errs"}, tx_bad, 0);
    check({tag, " rx_data_errs"}, rx_bad, 0);
    check({tag, " last_flag_errs"}, txl_bad + rxl_bad, 0);
    check({tag, " stall_errs"}, stall_err, 0);
    check({tag, " no_err_pulse"}, err_seen, 0);
    i_tx_ready = 1'b0;
    i_rx_ready = 1'b0;
  endtask

  initial begin
    int n_tx;
    int cyc;
    int dn;

    vecs[0] = '{n: 2'd2, enc: {1'b1, {190{1'b0}}, 1'b1},
                dec: {{128{1'b1}}, 4'b1011, 252'h0},
                rnd: 1'b0, poke: 1'b0, first_rx: 6'b011001};
    vecs[1] = '{n: 2'd3, enc: {6{32'h0F0F_3C3C}},
                dec: {6'b110100, {189{2'b10}}},
                rnd: 1'b0, poke: 1'b0, first_rx: 6'b001011};
    vecs[2] = '{n: 2'd2, enc: {6{32'hA5C3_0F1E}},
                dec: {12{32'h1234_5678}},
                rnd: 1'b1, poke: 1'b0, first_rx: 6'b010000};
    vecs[3] = '{n: 2'd3, enc: {6{32'h5A3C_E187}},
                dec: {12{32'hDEAD_BEEF}},
                rnd: 1'b1, poke: 1'b1, first_rx: 6'b111011};

    rst = 1'b0;
    i_start = 1'b1;
    i_code_n = 2'd2;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 13'h0);
    i_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 13'h0);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Illegal rates are rejected with a single error pulse.
    for (int bad = 0; bad < 2; bad++) begin
      @(negedge clk);
      i_code_n = 2'(bad); i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check($sformatf("err_pulse_n%0d", bad), {o_err, o_busy, o_tx_valid, o_rx_valid}, 4'b1000);
      @(negedge clk);
      check($sformatf("err_clear_n%0d", bad), {o_err, o_busy, o_tx_valid}, 3'b000);
    end

    // Reset in the middle of a frame aborts it without o_done.
    @(negedge clk);
    i_code_n = 2'd2; i_enc_frame = vecs[0].enc; i_dec_frame = vecs[2].dec;
    i_tx_ready = 1'b1; i_rx_ready = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_tx = 0;
    cyc = 0;
    while (n_tx < 50 && cyc < 1000) begin
      if (o_tx_valid && i_tx_ready) n_tx++;
      @(negedge clk);
      cyc++;
    end
    check("reached_tx_beat_50", n_tx, 50);
    rst = 1'b0;
    @(negedge clk);
    check("mid_frame_reset_outputs", all_outs(), 13'h0);
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done || o_tx_valid || o_rx_valid) dn++;
    end
    check("no_activity_after_abort", dn, 0);
    i_tx_ready = 1'b0;
    i_rx_ready = 1'b0;

    run_vec(vecs[0], "fresh_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
